instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Instruction-fetch stage directly upstream of the main controller.
- Holds the PC and issues word reads to instruction memory over a req/ready handshake.
- Registers the returned instruction into an IF/ID register and exposes opcode[31:26] and funct[5:0] to the controller.
- Supports stalls through a one-entry skid buffer and branch/jump redirects that flush the register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals PC (or the draining address, see DRAIN).
- imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  input  32  instruction word; valid only when imem_req and imem_ready are both 1.
- stall  input  1  downstream cannot accept a new IF/ID entry this cycle.
- redirect_valid  input  1  taken branch/jump; replace PC.
- redirect_pc  input  32  target address; bits [1:0] forced to 0 internally.
- ifid_valid  output  1  IF/ID register holds a live instruction.
- ifid_inst  output  32  registered instruction; 32'h0 when ifid_valid=0.
- ifid_pc4  output  32  address of ifid_inst + PC_STEP.
- opcode  output  6  ifid_inst[31:26], combinational from the register.
- funct  output  6  ifid_inst[5:0], combinational from the register.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, state=REQ, ifid_valid=0, ifid_inst=0, ifid_pc4=0, skid buffer empty.
  - imem_req=0 while rst_n=0.
  - Any response arriving during reset is ignored; reset mid-fetch aborts silently.
- States: REQ, HOLD, DRAIN.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with no redirect:
    - If stall=0 or ifid_valid=0: ifid_inst<=rdata, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4; stay in REQ.
    - If stall=1 and ifid_valid=1: skid<=rdata/pc+4, pc<=pc+4, go to HOLD.
  - No imem_ready: hold pc and address. imem_addr must not change while imem_req=1 and not ready.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID<=skid, go to REQ. The next fetch issues in the following cycle.
- stall=0 in REQ with no ready: ifid_valid<=0 (the entry was consumed, no replacement).
- stall=1: IF/ID contents are frozen.
- Redirect has priority over stall, ready, and hold in every state:
  - pc<=redirect_pc&~3, ifid_valid<=0, ifid_inst<=0, skid emptied.
  - In REQ with imem_ready=1: discard rdata, stay in REQ.
  - In REQ with imem_ready=0: the outstanding request must complete. Go to DRAIN, keep imem_req=1 with the old address, and latch the old address internally.
  - In HOLD: go to REQ.
- DRAIN:
  - imem_req=1 with the old address until imem_ready; data discarded; then go to REQ at the new pc.
  - A further redirect in DRAIN updates pc only.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No misalignment fault.
- Latency and throughput:
  - With imem_ready tied high: one instruction per cycle, first valid IF/ID one cycle after reset release.
  - Redirect costs one bubble when ready=1, more while draining.
- Bubbles present inst=0, so opcode=funct=6'b000000 (R-type nop to the controller).

Test Plan:
1. Reset release, imem_ready=1, memory word[i]=i → imem_addr 0,4,8,…; ifid_inst 0,1,2 on consecutive cycles; ifid_pc4 4,8,12.
2. Load 32'h8C22_0004 (LW) → opcode=6'b100011; load 32'h0043_0820 (ADD) → opcode=0, funct=6'b100000.
3. stall=1 for 3 cycles while a response arrives → state HOLD, imem_req=0, IF/ID frozen. After stall drops: skid contents appear, then the fetch resumes at the correct pc with no lost or duplicated word.
4. redirect_valid with redirect_pc=32'h0000_0102 while imem_ready=0 for 2 cycles → imem_addr held at the old address until ready, data dropped, next imem_addr=32'h0000_0100, ifid_valid=0 throughout.
5. redirect and stall asserted together in HOLD → flush wins: ifid_valid=0, skid discarded, pc=target.
6. RESET_PC=32'hFFFF_FFF8, two fetches → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst_n=0 mid-stream → next edge ifid_valid=0, pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads over a req/ready handshake,
// and feeds an IF/ID register (with a one-entry skid buffer) to the main controller.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic [31:0] pc_next;
    logic [31:0] redirect_target;

    assign pc_next         = pc_q + 32'(PC_STEP);
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_inst_d  = skid_inst_q;
        skid_pc4_d   = skid_pc4_q;

        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d         = redirect_target;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = 32'h0;
                    skid_inst_d  = 32'h0;
                    skid_pc4_d   = 32'h0;
                    // An unanswered request cannot be withdrawn; finish it at the old address.
                    if (!imem_ready) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_next;
                    if (!stall || !ifid_valid_q) begin
                        ifid_valid_d = 1'b1;
                        ifid_inst_d  = imem_rdata;
                        ifid_pc4_d   = pc_next;
                    end else begin
                        skid_inst_d = imem_rdata;
                        skid_pc4_d  = pc_next;
                        state_d     = ST_HOLD;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = 32'h0;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d         = redirect_target;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = 32'h0;
                    skid_inst_d  = 32'h0;
                    skid_pc4_d   = 32'h0;
                    state_d      = ST_REQ;
                end else if (!stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_inst_d  = skid_inst_q;
                    ifid_pc4_d   = skid_pc4_q;
                    skid_inst_d  = 32'h0;
                    skid_pc4_d   = 32'h0;
                    state_d      = ST_REQ;
                end
            end

            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_ready) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_inst_q  <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            skid_inst_q  <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign imem_req   = rst_n && (state_q != ST_HOLD);
    assign imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign opcode     = ifid_inst_q[31:26];
    assign funct      = ifid_inst_q[5:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a scoreboard of expected IF/ID entries is popped
// whenever the downstream consumes one, alongside direct address/handshake checks.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } entry_t;

    entry_t sb_q[$];
    entry_t mon_e;
    int     n_vec = 0;
    int     n_err = 0;

    localparam logic [31:0] LW_WORD  = 32'h8C22_0004;
    localparam logic [31:0] ADD_WORD = 32'h0043_0820;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_inst     (ifid_inst),
        .ifid_pc4      (ifid_pc4),
        .opcode        (opcode),
        .funct         (funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at byte address a is a/4, except two real instructions at 0x40/0x44.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: mem_word = LW_WORD;
            32'h0000_0044: mem_word = ADD_WORD;
            default:       mem_word = {2'b00, a[31:2]};
        endcase
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc4);
        entry_t e;
        e.inst = inst;
        e.pc4  = pc4;
        sb_q.push_back(e);
    endtask

    // Downstream consumer: a valid entry with stall low is taken at the next edge.
    always @(negedge clk) begin
        if (ifid_valid === 1'b1 && stall === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_underflow observed=%h expected=none", ifid_inst);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_inst", ifid_inst, mon_e.inst);
                chk("sb_pc4", ifid_pc4, mon_e.pc4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        imem_ready     = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_inst", ifid_inst, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h0);

        // Streaming fetch, one word per cycle.
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            push(32'(i), 32'(4 * i + 4));
            chk("stream_addr", imem_addr, 32'(4 * i));
            tick();
            chk("stream_valid", {31'h0, ifid_valid}, 32'h1);
            chk("stream_inst", ifid_inst, 32'(i));
        end

        // Redirect with ready high: fetched word discarded, one bubble.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
        chk("bubble_opcode", {26'h0, opcode}, 32'h0);
        chk("bubble_funct", {26'h0, funct}, 32'h0);
        chk("redir_addr", imem_addr, 32'h0000_0040);

        push(LW_WORD, 32'h44);
        push(ADD_WORD, 32'h48);
        tick();
        chk("lw_opcode", {26'h0, opcode}, 32'h23);
        tick();
        chk("add_opcode", {26'h0, opcode}, 32'h0);
        chk("add_funct", {26'h0, funct}, 32'h20);

        // Stall three cycles while a response arrives: it lands in the skid buffer.
        stall = 1'b1;
        push(32'h12, 32'h4C);
        push(32'h13, 32'h50);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_frozen", ifid_inst, ADD_WORD);
        end
        stall = 1'b0;
        tick();
        chk("skid_inst", ifid_inst, 32'h12);
        chk("resume_req", {31'h0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'h4C);
        tick();
        chk("resume_inst", ifid_inst, 32'h13);

        // Redirect while the request is unanswered: drain at the old address.
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("drain_addr0", imem_addr, 32'h50);
        chk("drain_req0", {31'h0, imem_req}, 32'h1);
        chk("drain_valid0", {31'h0, ifid_valid}, 32'h0);
        tick();
        chk("drain_addr1", imem_addr, 32'h50);
        chk("drain_valid1", {31'h0, ifid_valid}, 32'h0);
        imem_ready = 1'b1;
        tick();
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_valid", {31'h0, ifid_valid}, 32'h0);
        tick();
        chk("post_drain_inst", ifid_inst, 32'h40);

        // Stall into HOLD, then redirect with stall still high: flush wins.
        stall = 1'b1;
        tick();
        chk("hold2_req", {31'h0, imem_req}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
        chk("flush_inst", ifid_inst, 32'h0);
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_req", {31'h0, imem_req}, 32'h1);
        stall = 1'b0;
        push(32'h80, 32'h204);
        tick();
        chk("after_flush_inst", ifid_inst, 32'h80);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        push(32'h3FFF_FFFE, 32'hFFFF_FFFC);
        push(32'h3FFF_FFFF, 32'h0000_0000);
        tick();
        redirect_valid = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr2", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", ifid_pc4, 32'h0000_0000);

        // Reset mid-stream.
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("midrst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("midrst_inst", ifid_inst, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_addr", imem_addr, 32'h0);
        push(32'h0, 32'h4);
        tick();
        chk("refetch_inst", ifid_inst, 32'h0);
        chk("refetch_valid", {31'h0, ifid_valid}, 32'h1);
        tick();
        stall = 1'b1;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
